merge_out_line_packer: RTL

- Write-back end of the merger-tree datapath; performs the inverse of the input-side 512-bit line → 32-bit word unpacking.
- Accepts the merger tree's P=4 × 32-bit output tuples and packs four tuples into one 512-bit memory line.
- Presents lines with a word address on a valid/ready interface toward the memory write engine.
- Flags burst boundaries and end-of-stream, padding a partial final line.

---
 rtl/merge_pkg.sv | 29 ++
 rtl/merge_out_line_reg.sv | 53 +++++
 rtl/merge_out_line_packer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/merge_pkg.sv
// Shared constants, state type and line padding helper for the merger-tree
// write-back path (tuple-to-line packer and its output register).
package merge_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int P              = 4;
  localparam int LINE_WIDTH     = 512;
  localparam int BEAT_WIDTH     = P * DATA_WIDTH;
  localparam int BEATS          = LINE_WIDTH / BEAT_WIDTH;
  localparam int BEAT_CNT_W     = $clog2(BEATS);
  localparam int WORDS_PER_LINE = LINE_WIDTH / DATA_WIDTH;
  localparam int BURST_SIZE     = 16;
  localparam int ADDR_WIDTH     = 32;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Replace every record belonging to a beat at or above 'filled' with 'pad'.
  function automatic logic [LINE_WIDTH-1:0] pad_line(
    input logic [LINE_WIDTH-1:0] line,
    input logic [BEAT_CNT_W-1:0] filled,
    input logic [DATA_WIDTH-1:0] pad
  );
    logic [LINE_WIDTH-1:0] res;
    res = line;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if ((w / P) >= int'(filled)) res[w*DATA_WIDTH +: DATA_WIDTH] = pad;
    end
    return res;
  endfunction
endpackage

// File: rtl/merge_out_line_reg.sv
// Output holding register for packed lines: valid/ready toward the memory
// write engine plus address, burst-first and last-line sideband.
module merge_out_line_reg
  import merge_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [LINE_WIDTH-1:0] load_line,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  load_first,
  input  logic                  load_last,
  input  logic                  set_last,
  input  logic                  line_ready,
  output logic [LINE_WIDTH-1:0] line,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  line_valid,
  output logic                  burst_first,
  output logic                  line_last,
  output logic                  free,
  output logic                  handshake
);

  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line        <= '0;
      addr        <= '0;
      line_valid  <= 1'b0;
      burst_first <= 1'b0;
      last_q      <= 1'b0;
    end else if (load) begin
      line        <= load_line;
      addr        <= load_addr;
      line_valid  <= 1'b1;
      burst_first <= load_first;
      last_q      <= load_last;
    end else if (handshake) begin
      line_valid  <= 1'b0;
      burst_first <= 1'b0;
      last_q      <= 1'b0;
    end else if (set_last) begin
      last_q      <= 1'b1;
    end
  end

  // A flush landing on a held line marks it last even if it leaves this cycle.
  assign line_last = last_q | (set_last & line_valid);
  assign free      = ~line_valid | line_ready;
  assign handshake = line_valid & line_ready;

endmodule

// File: rtl/merge_out_line_packer.sv
// Packs P-record merger-tree tuples into 512-bit memory lines with word
// addresses, burst markers and end-of-stream padding.
// Optional in-order checker enabled by defining MERGE_OUT_ORDER_CHECK_EN.
module merge_out_line_packer
  import merge_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] PAD_WORD = 32'h0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [BEAT_WIDTH-1:0]   i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_flush,
  output logic [LINE_WIDTH-1:0]   o_line,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic                    o_line_valid,
  input  logic                    i_line_ready,
  output logic                    o_burst_first,
  output logic                    o_line_last,
  output logic                    o_done,
  output logic [31:0]             o_line_count
`ifdef MERGE_OUT_ORDER_CHECK_EN
  ,
  output logic                    o_order_err
`endif
);

  state_t                  state, state_nx;
  logic [BEAT_CNT_W-1:0]   beat_cnt_p0;
  logic [LINE_WIDTH-1:0]   acc_p0;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic [31:0]             line_idx;
  logic [31:0]             line_count;

  logic                    vld_p1, free_p1, hs_p1, last_p1;
  logic                    start_ok, accept, last_beat;
  logic                    ld, ld_last, set_last;
  logic                    ld_first;
  logic [LINE_WIDTH-1:0]   ld_line, full_line;
  logic [ADDR_WIDTH-1:0]   ld_addr;

  assign start_ok  = i_start & ((state == IDLE) | (state == DONE));
  // The only beat that can stall is the one that must move into the output register.
  assign o_ready   = (state == RUN) &
                     ((beat_cnt_p0 != BEAT_CNT_W'(BEATS-1)) | free_p1);
  assign accept    = i_valid & o_ready;
  assign last_beat = accept & (beat_cnt_p0 == BEAT_CNT_W'(BEATS-1));
  assign full_line = {i_data, acc_p0[LINE_WIDTH-BEAT_WIDTH-1:0]};
  assign ld_addr   = base_addr + ADDR_WIDTH'(line_idx) * ADDR_WIDTH'(WORDS_PER_LINE);
  assign ld_first  = (line_idx % 32'(BURST_SIZE)) == 32'd0;

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_line  = full_line;
    ld_last  = 1'b0;
    set_last = 1'b0;
    case (state)
      IDLE: if (i_start) state_nx = RUN;
      RUN: begin
        if (last_beat) ld = 1'b1;
        if (i_flush) begin
          if (last_beat) begin
            ld_last  = 1'b1;
            state_nx = FLUSH;
          end else if (accept || (beat_cnt_p0 != '0)) begin
            state_nx = FLUSH;
          end else if (vld_p1) begin
            set_last = 1'b1;
            state_nx = i_line_ready ? DONE : FLUSH;
          end else begin
            state_nx = DONE;
          end
        end
      end
      FLUSH: begin
        if ((beat_cnt_p0 != '0) && free_p1) begin
          ld      = 1'b1;
          ld_line = pad_line(acc_p0, beat_cnt_p0, PAD_WORD);
          ld_last = 1'b1;
        end
        if (hs_p1 && last_p1) state_nx = DONE;
      end
      DONE: if (i_start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // ---- stage p0: accumulator and line bookkeeping ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      beat_cnt_p0 <= '0;
      acc_p0      <= '0;
      base_addr   <= '0;
      line_idx    <= '0;
      line_count  <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        base_addr   <= i_base_addr;
        beat_cnt_p0 <= '0;
        line_idx    <= '0;
        line_count  <= '0;
      end else begin
        if (accept) begin
          acc_p0[beat_cnt_p0*BEAT_WIDTH +: BEAT_WIDTH] <= i_data;
          beat_cnt_p0 <= last_beat ? '0 : beat_cnt_p0 + 1'b1;
        end else if (ld) begin
          beat_cnt_p0 <= '0;
        end
        if (ld)    line_idx   <= line_idx + 32'd1;
        if (hs_p1) line_count <= line_count + 32'd1;
      end
    end
  end

  // ---- stage p1: output holding register ----
  merge_out_line_reg u_line_reg (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .load        (ld),
    .load_line   (ld_line),
    .load_addr   (ld_addr),
    .load_first  (ld_first),
    .load_last   (ld_last),
    .set_last    (set_last),
    .line_ready  (i_line_ready),
    .line        (o_line),
    .addr        (o_addr),
    .line_valid  (vld_p1),
    .burst_first (o_burst_first),
    .line_last   (last_p1),
    .free        (free_p1),
    .handshake   (hs_p1)
  );

  assign o_line_valid = vld_p1;
  assign o_line_last  = last_p1;
  assign o_done       = (state == DONE);
  assign o_line_count = line_count;

`ifdef MERGE_OUT_ORDER_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_rec;
  logic                  have_prev;
  logic                  order_bad;
  logic [DATA_WIDTH-1:0] cmp_rec;
  logic [DATA_WIDTH-1:0] cur_rec;
  logic                  cmp_ok;

  // Walk the beat in record order, chaining from the last record seen before it.
  always_comb begin
    order_bad = 1'b0;
    cmp_rec   = prev_rec;
    cmp_ok    = have_prev;
    cur_rec   = '0;
    for (int r = 0; r < P; r++) begin
      cur_rec = i_data[r*DATA_WIDTH +: DATA_WIDTH];
      if (cmp_ok && (cur_rec < cmp_rec)) order_bad = 1'b1;
      cmp_rec = cur_rec;
      cmp_ok  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_rec    <= '0;
      have_prev   <= 1'b0;
      o_order_err <= 1'b0;
    end else if (start_ok) begin
      have_prev   <= 1'b0;
      o_order_err <= 1'b0;
    end else if (accept) begin
      prev_rec  <= i_data[BEAT_WIDTH-1 -: DATA_WIDTH];
      have_prev <= 1'b1;
      if (order_bad) o_order_err <= 1'b1;
    end
  end
`endif

endmodule
